unified_mem_responder: RTL

Memory-side responder for the RV32E core. It serves both the core's instruction-fetch port (`inst_addr`/`instruction`/`inst_ready`) and its data SRAM port (`sram_*`) from one internal single-ported word array. The data port always wins the array, so instruction fetch stalls the core through `inst_ready`. A word-wide preload port fills the array before or during boot.

---
 rtl/unified_mem_responder.sv | 94 +++++++++
 1 files changed

// File: rtl/unified_mem_responder.sv
// unified_mem_responder: one word array serving instruction fetch, data SRAM port and preload
module unified_mem_responder #(
    parameter int          ADDR_W    = 12,
    parameter int          INST_WAIT = 1,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       inst_addr,
    output logic [31:0]       instruction,
    output logic              inst_ready,
    input  logic              sram_cen,
    input  logic              sram_wen,
    input  logic [3:0]        sram_ben,
    input  logic [31:0]       sram_addr,
    input  logic [31:0]       sram_din,
    output logic [31:0]       sram_dout,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data
);
    localparam logic [1:0] S_ISSUE = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam logic [3:0] WAIT_INIT = 4'(INST_WAIT);

    logic [31:0]       mem [0:(2**ADDR_W)-1];
    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] fa_q;
    logic [ADDR_W-1:0] ia;
    logic [ADDR_W-1:0] dw;
    logic              data_acc;
    logic              free;
    logic              redirect;
    logic              inst_rd;
    logic              unused_bits;

    assign ia          = inst_addr[ADDR_W+1:2];
    assign dw          = sram_addr[ADDR_W+1:2];
    assign data_acc    = !load_en && !sram_cen;
    assign free        = !load_en && sram_cen;
    assign redirect    = ia != fa_q;
    assign inst_rd     = state == S_WAIT && !redirect && cnt == 4'd0 && free;
    assign inst_ready  = state == S_RESP;
    assign unused_bits = ^{inst_addr[31:ADDR_W+2], inst_addr[1:0], sram_addr[31:ADDR_W+2], sram_addr[1:0]};

    // Array writes: preload wins, otherwise lane-masked data write; never reset
    always_ff @(posedge clk) begin
        if (load_en)
            mem[load_addr] <= load_data;
        else if (!sram_cen && !sram_wen)
            for (int i = 0; i < 4; i++)
                if (!sram_ben[i]) mem[dw][8*i +: 8] <= sram_din[8*i +: 8];
    end

    // Data read port: full word, holds on writes, idle and preload cycles
    always_ff @(posedge clk) begin
        if (rst)
            sram_dout <= 32'h0;
        else if (data_acc && sram_wen)
            sram_dout <= mem[dw];
    end

    // Fetch read only when the array is free and the address is still current
    always_ff @(posedge clk) begin
        if (rst)
            instruction <= NOP_WORD;
        else if (inst_rd)
            instruction <= mem[fa_q];
    end

    // Fetch FSM: issue, count down wait cycles, then respond once the array is free
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_ISSUE;
            cnt   <= 4'd0;
            fa_q  <= '0;
        end else if (state == S_ISSUE) begin
            fa_q  <= ia;
            cnt   <= WAIT_INIT;
            state <= S_WAIT;
        end else if (state == S_WAIT) begin
            if (redirect)
                state <= S_ISSUE;
            else if (cnt != 4'd0)
                cnt <= cnt - 4'd1;
            else if (free)
                state <= S_RESP;
        end else begin
            state <= S_ISSUE;
        end
    end
endmodule
